// File: rtl/data_mem_bridge.sv
// Data-side memory bridge for the core's memory stage: scratch RAM, a polled
// camera pixel FIFO with status/control registers, and a GPIO output register.
module data_mem_bridge #(
    parameter int          RAM_WORDS  = 64,
    parameter int          FIFO_DEPTH = 16,
    parameter int          PIX_W      = 16,
    parameter logic [31:0] CAM_BASE   = 32'h0000_1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      addr,
    input  logic [31:0]      write_data,
    input  logic             write_enable,
    output logic [31:0]      read_data,
    input  logic             pix_valid,
    input  logic [PIX_W-1:0] pix_data,
    output logic             pix_ready,
    output logic [31:0]      gpio_out
);

    localparam int AW = $clog2(RAM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [29:0] CAM_W = CAM_BASE[31:2];

    // ------------------------------------------------------------------
    // Address decode (word granularity; byte offset bits are don't-care)
    // ------------------------------------------------------------------
    logic [29:0] waddr;
    logic        sel_ram, sel_data, sel_stat, sel_pop, sel_ctrl, sel_gpio;
    logic        unused_addr_lsb;

    assign waddr           = addr[31:2];
    assign unused_addr_lsb = &{1'b0, addr[1:0]};

    assign sel_ram  = (addr[31:AW+2] == '0);
    assign sel_data = (waddr == CAM_W);
    assign sel_stat = (waddr == CAM_W + 30'd1);
    assign sel_pop  = (waddr == CAM_W + 30'd2);
    assign sel_ctrl = (waddr == CAM_W + 30'd3);
    assign sel_gpio = (waddr == CAM_W + 30'd4);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0]      ram_q  [RAM_WORDS];
    logic [PIX_W-1:0] fifo_q [FIFO_DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          ovf_q,    ovf_d;
    logic          cap_en_q, cap_en_d;
    logic [31:0]   gpio_q,   gpio_d;

    logic full, empty, push, pop, flush, ram_we, ctrl_we, gpio_we;

    assign full  = (count_q == CW'(FIFO_DEPTH));
    assign empty = (count_q == '0);

    assign pix_ready = cap_en_q & ~full;
    assign push      = pix_valid & pix_ready;
    assign ram_we    = write_enable & sel_ram;
    assign ctrl_we   = write_enable & sel_ctrl;
    assign gpio_we   = write_enable & sel_gpio;
    assign pop       = write_enable & sel_pop & ~empty;
    assign flush     = ctrl_we & write_data[1];

    // ------------------------------------------------------------------
    // Next-state logic; flush overrides any push/pop in the same cycle
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        ovf_d    = ovf_q | (pix_valid & cap_en_q & full);
        cap_en_d = cap_en_q;
        gpio_d   = gpio_q;

        if (push)    wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)     rd_ptr_d = rd_ptr_q + PW'(1);
        if (ctrl_we) cap_en_d = write_data[0];
        if (gpio_we) gpio_d   = write_data;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            cap_en_q <= 1'b0;
            gpio_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            cap_en_q <= cap_en_d;
            gpio_q   <= gpio_d;
        end
    end

    // Storage arrays carry no reset; FIFO contents are only visible while count>0
    always_ff @(posedge clk) begin
        if (ram_we) ram_q[addr[AW+1:2]] <= write_data;
        if (push && !flush) fifo_q[wr_ptr_q] <= pix_data;
    end

    assign gpio_out = gpio_q;

    // ------------------------------------------------------------------
    // Combinational load path
    // ------------------------------------------------------------------
    logic [31:0] head_word, status_word;

    assign head_word   = empty ? 32'd0 : 32'(fifo_q[rd_ptr_q]);
    assign status_word = {20'd0, cap_en_q, ovf_q, full, empty, 8'(count_q)};

    always_comb begin
        read_data = 32'd0;
        if (sel_ram)       read_data = ram_q[addr[AW+1:2]];
        else if (sel_data) read_data = head_word;
        else if (sel_stat) read_data = status_word;
        else if (sel_ctrl) read_data = {31'd0, cap_en_q};
        else if (sel_gpio) read_data = gpio_q;
    end

endmodule

// File: tb/tb_data_mem_bridge.sv
// Self-checking bench for data_mem_bridge: vector table for the address map,
// pixel scoreboard queue for FIFO ordering, plus hand-written corner sequences.
module tb_data_mem_bridge;

    localparam logic [31:0] A_DATA = 32'h0000_1000;
    localparam logic [31:0] A_STAT = 32'h0000_1004;
    localparam logic [31:0] A_POP  = 32'h0000_1008;
    localparam logic [31:0] A_CTRL = 32'h0000_100C;
    localparam logic [31:0] A_GPIO = 32'h0000_1010;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr, write_data, read_data, gpio_out;
    logic        write_enable, pix_valid, pix_ready;
    logic [15:0] pix_data;

    data_mem_bridge dut (
        .clk(clk), .reset(reset), .addr(addr), .write_data(write_data),
        .write_enable(write_enable), .read_data(read_data),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
        .gpio_out(gpio_out)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model of the peripheral block
    logic [15:0] sbq[$];
    logic        cap_m = 1'b0;
    logic        ovf_m = 1'b0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic        chk;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr = a; write_data = d; write_enable = 1'b1;
        cyc();
        write_enable = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string nm);
        addr = a; write_enable = 1'b0;
        #1;
        chk(nm, read_data, exp);
    endtask

    function automatic logic [31:0] stat_m();
        logic full_m;
        full_m = (sbq.size() == 16);
        return {20'd0, cap_m, ovf_m, full_m, (sbq.size() == 0), 8'(sbq.size())};
    endfunction

    function automatic logic [31:0] head_m();
        return (sbq.size() > 0) ? 32'(sbq[0]) : 32'd0;
    endfunction

    task automatic ctrl(input logic [31:0] d);
        wr(A_CTRL, d);
        cap_m = d[0];
        if (d[1]) begin
            sbq.delete();
            ovf_m = 1'b0;
        end
    endtask

    task automatic pix(input logic [15:0] d);
        logic acc;
        acc = cap_m && (sbq.size() < 16);
        pix_valid = 1'b1; pix_data = d;
        #1;
        chk("pix_ready", 32'(pix_ready), 32'(acc));
        cyc();
        pix_valid = 1'b0;
        if (acc) sbq.push_back(d);
        else if (cap_m) ovf_m = 1'b1;
    endtask

    task automatic pop_chk(input string nm);
        rd(A_DATA, head_m(), nm);
        wr(A_POP, 32'hFFFF_FFFF);
        if (sbq.size() > 0) void'(sbq.pop_front());
    endtask

    initial begin
        tbl[0]  = '{32'h0000_0008, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0};
        tbl[1]  = '{32'h0000_00FC, 32'h1234_5678, 1'b1, 1'b0, 32'h0};
        tbl[2]  = '{32'h0000_0008, 32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF};
        tbl[3]  = '{32'h0000_00FC, 32'h0,         1'b0, 1'b1, 32'h1234_5678};
        tbl[4]  = '{32'h0000_000A, 32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF};
        tbl[5]  = '{32'h0000_0100, 32'h5555_5555, 1'b1, 1'b1, 32'h0};
        tbl[6]  = '{32'h0000_0008, 32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF};
        tbl[7]  = '{A_DATA,        32'h0,         1'b0, 1'b1, 32'h0};
        tbl[8]  = '{A_STAT,        32'h0,         1'b0, 1'b1, 32'h0000_0100};
        tbl[9]  = '{A_POP,         32'h0,         1'b0, 1'b1, 32'h0};
        tbl[10] = '{A_CTRL,        32'h0,         1'b0, 1'b1, 32'h0};
        tbl[11] = '{A_GPIO,        32'h0,         1'b0, 1'b1, 32'h0};

        reset = 1'b1; addr = '0; write_data = '0; write_enable = 1'b0;
        pix_valid = 1'b0; pix_data = '0;
        cyc(); cyc();
        reset = 1'b0;
        cyc();

        // Reset state
        chk("rst_gpio", gpio_out, 32'h0);
        chk("rst_pix_ready", 32'(pix_ready), 32'h0);
        rd(A_STAT, stat_m(), "rst_status");

        // Address map vectors
        for (int i = 0; i < 12; i++) begin
            if (tbl[i].we) wr(tbl[i].addr, tbl[i].wdata);
            if (tbl[i].chk) rd(tbl[i].addr, tbl[i].exp, $sformatf("map[%0d]", i));
        end

        // Basic capture and pop
        ctrl(32'h1);
        for (int i = 1; i <= 3; i++) pix(16'(i));
        rd(A_STAT, stat_m(), "stat_cnt3");
        pop_chk("head_1");
        rd(A_DATA, head_m(), "head_2");
        rd(A_STAT, stat_m(), "stat_cnt2");
        pop_chk("drain_a");
        pop_chk("drain_b");

        // Fill past full: 17th pixel dropped and overflow set
        for (int i = 0; i < 17; i++) pix(16'h0100 + 16'(i));
        #1 chk("full_pix_ready", 32'(pix_ready), 32'h0);
        rd(A_STAT, stat_m(), "stat_full_ovf");
        for (int i = 0; i < 16; i++) pop_chk($sformatf("drain16[%0d]", i));
        rd(A_STAT, stat_m(), "stat_empty_ovf");
        rd(A_DATA, 32'h0, "data_empty");

        // Simultaneous push and pop at count=5
        ctrl(32'h3);
        for (int i = 0; i < 5; i++) pix(16'h0200 + 16'(i));
        pix_valid = 1'b1; pix_data = 16'h0205;
        addr = A_POP; write_data = '0; write_enable = 1'b1;
        #1 chk("pushpop_ready", 32'(pix_ready), 32'h1);
        cyc();
        write_enable = 1'b0; pix_valid = 1'b0;
        sbq.push_back(16'h0205);
        void'(sbq.pop_front());
        rd(A_STAT, stat_m(), "stat_pushpop");
        rd(A_DATA, 32'h0000_0201, "head_pushpop");
        for (int i = 0; i < 5; i++) pop_chk($sformatf("drain5[%0d]", i));

        // Pop while empty, then check pointers still line up
        wr(A_POP, 32'h0);
        rd(A_STAT, stat_m(), "stat_pop_empty");
        pix(16'h0300);
        rd(A_DATA, 32'h0000_0300, "head_after_empty_pop");
        pop_chk("drain_300");

        // Flush while full with overflow and pixel still offered
        for (int i = 0; i < 17; i++) pix(16'h0400 + 16'(i));
        rd(A_STAT, stat_m(), "stat_prefull");
        pix_valid = 1'b1; pix_data = 16'hBEEF;
        ctrl(32'h3);
        pix_valid = 1'b0;
        rd(A_STAT, 32'h0000_0900, "stat_flush");
        rd(A_CTRL, 32'h1, "ctrl_flush");
        rd(A_DATA, 32'h0, "data_flush");

        // GPIO and unmapped region
        wr(A_GPIO, 32'hA5A5_A5A5);
        chk("gpio_out", gpio_out, 32'hA5A5_A5A5);
        rd(A_GPIO, 32'hA5A5_A5A5, "gpio_rd");
        wr(32'h0000_2000, 32'h1111_1111);
        rd(32'h0000_2000, 32'h0, "unmapped");

        // Reset mid-stream, checked before any clock edge
        for (int i = 0; i < 4; i++) pix(16'h0500 + 16'(i));
        addr = A_STAT;
        pix_valid = 1'b1;
        #1 reset = 1'b1;
        #1;
        chk("midrst_gpio", gpio_out, 32'h0);
        chk("midrst_pix_ready", 32'(pix_ready), 32'h0);
        chk("midrst_status", read_data, 32'h0000_0100);
        pix_valid = 1'b0;
        cyc();
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
